// File: rtl/time_display_mux.sv
// Scans an 8-digit common-anode 7-segment display from a frame-synchronous
// shadow of the packed time word, with per-digit blink and decimal points.
module time_display_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hora_completa,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    logic [CW-1:0] r_count;
    logic [2:0]    r_index;
    logic [31:0]   r_shadow;
    logic [FW-1:0] r_frame_cnt;
    phase_t        r_phase;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_start;

    logic          w_tick;
    logic          w_wrap;
    logic [3:0]    w_nibble;
    logic          w_blank;
    logic [7:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;

    assign w_tick = (r_count == CNT_MAX);
    assign w_wrap = w_tick && (r_index == 3'd7);

    // hora_completa is only sampled on the 7->0 wrap so a frame never mixes two time words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= '0;
            r_index       <= 3'd0;
            r_shadow      <= 32'd0;
            r_frame_cnt   <= '0;
            r_phase       <= PH_ON;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_tick) begin
                r_count <= '0;
                r_index <= r_index + 3'd1;
            end else begin
                r_count <= r_count + 1'b1;
            end
            if (w_wrap) begin
                r_shadow <= hora_completa;
                if (r_frame_cnt == FRM_MAX) begin
                    r_frame_cnt <= '0;
                    r_phase     <= (r_phase == PH_ON) ? PH_OFF : PH_ON;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_nibble  = r_shadow[{r_index, 2'b00} +: 4];
        w_blank   = blink_mask[r_index] && (r_phase == PH_OFF);
        w_an_nxt  = ~(8'b0000_0001 << r_index);
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = ~dp_in[r_index];
        // Separator slots win over blinking so the colon-like dashes never flash.
        if (r_index == 3'd2 || r_index == 3'd5) begin
            w_seg_nxt = 7'h3F;
        end else if (w_blank) begin
            w_seg_nxt = 7'h7F;
            w_dp_nxt  = 1'b1;
        end else begin
            case (w_nibble)
                4'd0:    w_seg_nxt = 7'h40;
                4'd1:    w_seg_nxt = 7'h79;
                4'd2:    w_seg_nxt = 7'h24;
                4'd3:    w_seg_nxt = 7'h30;
                4'd4:    w_seg_nxt = 7'h19;
                4'd5:    w_seg_nxt = 7'h12;
                4'd6:    w_seg_nxt = 7'h02;
                4'd7:    w_seg_nxt = 7'h78;
                4'd8:    w_seg_nxt = 7'h00;
                4'd9:    w_seg_nxt = 7'h10;
                default: w_seg_nxt = 7'h7F;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;

endmodule
